// File: rtl/tx_bank_sched.sv
// Ping-pong bank scheduler for the 512x16 TX buffer: fills one 256-word bank while the other is sent.
// Optional macro TX_FLUSH_EN force-closes a partial bank after FLUSH_CYCLES idle cycles.
module tx_bank_sched #(
  parameter int ADDR_NBIT    = 8,
  parameter int DATA_NBIT    = 16,
  parameter int FLUSH_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_vd,
  input  logic [DATA_NBIT-1:0] wr_data,
  input  logic                 wr_eop,
  output logic                 wr_ready,
  output logic                 buf_wren,
  output logic [ADDR_NBIT:0]   buf_wraddr,
  output logic [DATA_NBIT-1:0] buf_wrdata,
  output logic                 tx_req,
  output logic                 tx_bank,
  output logic [ADDR_NBIT:0]   tx_len,
  input  logic                 tx_done,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  typedef enum logic {S_IDLE, S_SEND} rd_state_t;

  rd_state_t              r_state, w_state_nxt;
  logic                   r_wbank, r_rbank;
  logic [ADDR_NBIT-1:0]   r_wptr;
  logic [1:0]             r_full, w_full_nxt;
  logic [ADDR_NBIT:0]     r_len0, r_len1;
  logic [ADDR_NBIT:0]     w_close_len, w_rlen;
  logic                   w_accept, w_eop_close, w_flush_close, w_close, w_done;
  logic                   r_buf_wren, r_tx_bank, r_ovf;
  logic [ADDR_NBIT:0]     r_buf_wraddr, r_tx_len;
  logic [DATA_NBIT-1:0]   r_buf_wrdata;

  assign wr_ready    = ~r_full[r_wbank];
  assign w_accept    = wr_vd & wr_ready;
  assign w_eop_close = w_accept & (wr_eop | (&r_wptr));
  assign w_close     = w_eop_close | w_flush_close;
  // An eop/last word is itself stored, so it counts; a flush closes on what is already there.
  assign w_close_len = w_eop_close ? ({1'b0, r_wptr} + (ADDR_NBIT+1)'(1)) : {1'b0, r_wptr};
  assign w_rlen      = r_rbank ? r_len1 : r_len0;
  assign w_done      = (r_state == S_SEND) & tx_done;

`ifdef TX_FLUSH_EN
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES);
  logic [FLUSH_W-1:0] r_idle_cnt;
  logic               w_idle;

  assign w_idle        = (r_wptr != '0) & ~w_accept;
  assign w_flush_close = w_idle & ~r_full[r_wbank] &
                         (r_idle_cnt == FLUSH_W'(FLUSH_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (w_idle && !w_flush_close) begin
      r_idle_cnt <= r_idle_cnt + FLUSH_W'(1);
    end else begin
      r_idle_cnt <= '0;
    end
  end
`else
  // Without flush a partial bank waits for eop or the 256th word; this is constant 0.
  assign w_flush_close = (FLUSH_CYCLES < 0);
`endif

  always_comb begin
    w_full_nxt = r_full;
    if (w_close) w_full_nxt[r_wbank] = 1'b1;
    if (w_done)  w_full_nxt[r_rbank] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_full[r_rbank]) w_state_nxt = S_SEND;
      S_SEND:  if (tx_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Writer side: bank pointer, occupancy and per-bank lengths
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbank <= 1'b0;
      r_wptr  <= '0;
      r_full  <= '0;
      r_len0  <= '0;
      r_len1  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_close) begin
        r_wbank <= ~r_wbank;
        r_wptr  <= '0;
        if (r_wbank) r_len1 <= w_close_len;
        else         r_len0 <= w_close_len;
      end else if (w_accept) begin
        r_wptr <= r_wptr + ADDR_NBIT'(1);
      end
    end
  end

  // Registered buffer write port and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_wren   <= 1'b0;
      r_buf_wraddr <= '0;
      r_buf_wrdata <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_buf_wren <= w_accept;
      if (w_accept) begin
        r_buf_wraddr <= {r_wbank, r_wptr};
        r_buf_wrdata <= wr_data;
      end
      if (ovf_clr)                r_ovf <= 1'b0;
      else if (wr_vd && !wr_ready) r_ovf <= 1'b1;
    end
  end

  // Reader side: request latches bank/length on launch and holds them while sending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rbank   <= 1'b0;
      r_tx_bank <= 1'b0;
      r_tx_len  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && r_full[r_rbank]) begin
        r_tx_bank <= r_rbank;
        r_tx_len  <= w_rlen;
      end
      if (w_done) r_rbank <= ~r_rbank;
    end
  end

  assign buf_wren   = r_buf_wren;
  assign buf_wraddr = r_buf_wraddr;
  assign buf_wrdata = r_buf_wrdata;
  assign tx_req     = (r_state == S_SEND);
  assign tx_bank    = r_tx_bank;
  assign tx_len     = r_tx_len;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_tx_bank_sched.sv
// Bench for tx_bank_sched: directed scenarios plus random traffic against a packet-queue model.
module tb_tx_bank_sched;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;
`ifdef TX_FLUSH_EN
  localparam int FLUSH = 16;
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam int FLUSH = 4096;
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_vd = 1'b0, wr_eop = 1'b0, tx_done = 1'b0, ovf_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, buf_wren, tx_req, tx_bank, ovf;
  logic [AW:0]   buf_wraddr, tx_len;
  logic [DW-1:0] buf_wrdata;

  tx_bank_sched #(.ADDR_NBIT(AW), .DATA_NBIT(DW), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_vd(wr_vd), .wr_data(wr_data), .wr_eop(wr_eop), .wr_ready(wr_ready),
    .buf_wren(buf_wren), .buf_wraddr(buf_wraddr), .buf_wrdata(buf_wrdata),
    .tx_req(tx_req), .tx_bank(tx_bank), .tx_len(tx_len), .tx_done(tx_done),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Model: closed banks waiting/being sent, in close order, plus the open bank's fill level.
  typedef struct {
    int bank;
    int len;
    int close_t;
  } pkt_t;

  pkt_t q[$];
  int   cyc, m_bank, m_cnt, m_idle, head_start;
  int   exp_wren, exp_addr, exp_data, exp_ovf;

  task automatic model_reset();
    q.delete();
    cyc = 0; m_bank = 0; m_cnt = 0; m_idle = 0; head_start = 0;
    exp_wren = 0; exp_addr = 0; exp_data = 0; exp_ovf = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_wr_ready"}, wr_ready, 1);
    check_val({tag, "_tx_req"}, tx_req, 0);
    check_val({tag, "_tx_bank"}, tx_bank, 0);
    check_val({tag, "_tx_len"}, tx_len, 0);
    check_val({tag, "_buf_wren"}, buf_wren, 0);
    check_val({tag, "_buf_wraddr"}, buf_wraddr, 0);
    check_val({tag, "_buf_wrdata"}, buf_wrdata, 0);
    check_val({tag, "_ovf"}, ovf, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic apply_reset();
    wr_vd = 0; wr_eop = 0; tx_done = 0; ovf_clr = 0; wr_data = '0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 model_reset();
  endtask

  task automatic close_bank(input int len);
    pkt_t p;
    p.bank = m_bank; p.len = len; p.close_t = cyc;
    q.push_back(p);
    if (q.size() == 1) head_start = cyc + 2;
    m_bank ^= 1;
    m_cnt = 0;
  endtask

  // One clock: check this cycle's outputs, drive inputs, advance the model, wait for the edge.
  task automatic step(input bit vd, input bit eop, input bit done, input bit clr, input logic [DW-1:0] data);
    bit req_exp, ready, accept;
    req_exp = (q.size() > 0) && (cyc >= head_start);
    ready   = (q.size() < 2);
    check_val("wr_ready", wr_ready, ready);
    check_val("tx_req", tx_req, req_exp);
    if (req_exp) begin
      check_val("tx_bank", tx_bank, q[0].bank);
      check_val("tx_len", tx_len, q[0].len);
    end
    check_val("buf_wren", buf_wren, exp_wren);
    if (exp_wren != 0) begin
      check_val("buf_wraddr", buf_wraddr, exp_addr);
      check_val("buf_wrdata", buf_wrdata, exp_data);
    end
    check_val("ovf", ovf, exp_ovf);

    wr_vd = vd; wr_eop = eop; tx_done = done; ovf_clr = clr; wr_data = data;

    accept   = vd && ready;
    exp_wren = accept;
    if (clr)              exp_ovf = 0;
    else if (vd && !ready) exp_ovf = 1;
    if (done && req_exp) begin
      void'(q.pop_front());
      if (q.size() > 0) head_start = (q[0].close_t + 2 > cyc + 2) ? q[0].close_t + 2 : cyc + 2;
    end
    if (accept) begin
      exp_addr = m_bank * DEPTH + m_cnt;
      exp_data = data;
      m_cnt++;
      m_idle = 0;
      if (eop || m_cnt == DEPTH) close_bank(m_cnt);
    end else if (FLUSH_ON && m_cnt != 0) begin
      if (m_idle == FLUSH - 1) begin
        close_bank(m_cnt);
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end else begin
      m_idle = 0;
    end

    @(posedge clk);
    #1 cyc++;
  endtask

  task automatic idle(input int n, input bit done);
    for (int i = 0; i < n; i++) step(0, 0, done, 0, '0);
  endtask

  initial begin
    model_reset();
    #3 check_reset_outputs("init");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Short packet of 10 words, request held until done
    for (int i = 1; i <= 10; i++) step(1, i == 10, 0, 0, DW'(i));
    idle(20, 0);
    check_val("pkt10_len", tx_len, 10);
    check_val("pkt10_bank", tx_bank, 0);
    idle(1, 1);
    idle(5, 0);

    // 300 words without eop: bank0 closes at 256, the rest spill into bank1
    apply_reset();
    for (int i = 1; i <= 300; i++) step(1, 0, 0, 0, DW'(i));
    idle(4, 0);
    check_val("full_len", tx_len, 256);

    // Both banks full, overflow, clear, then free bank0 and overlap close with done
    apply_reset();
    for (int i = 0; i < 3; i++) step(1, i == 2, 0, 0, DW'(16'h100 + i));
    for (int i = 0; i < 2; i++) step(1, i == 1, 0, 0, DW'(16'h200 + i));
    step(1, 0, 0, 0, 16'hDEAD);
    step(0, 0, 0, 0, '0);
    check_val("ovf_set", ovf, 1);
    check_val("ovf_ready", wr_ready, 0);
    step(0, 0, 0, 1, '0);
    step(0, 0, 1, 0, '0);
    idle(3, 0);
    step(1, 1, 1, 0, 16'h0300);
    idle(6, 1);

    // Random traffic with varying writer/reader pressure
    apply_reset();
    for (int ph = 0; ph < 6; ph++) begin
      int p_vd, p_eop, p_done;
      p_vd   = 40 + 10 * ph;
      p_eop  = (ph % 2 == 0) ? 3 : 30;
      p_done = (ph < 3) ? 40 : 5;
      for (int i = 0; i < 500; i++)
        step($urandom_range(99) < p_vd, $urandom_range(99) < p_eop,
             $urandom_range(99) < p_done, $urandom_range(99) < 4, DW'($urandom));
    end
    idle(20, 1);

    // Partial bank followed by a long idle stretch
    apply_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, DW'(16'h500 + i));
    idle(1000, 0);
    idle(4, 1);

    // Reset while traffic is in flight
    for (int i = 0; i < 7; i++) step(1, i == 3, 0, 0, DW'($urandom));
    apply_reset();
    idle(4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
